// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared constants, log2 helper and entry type for the PIFO queues
package pifo_pkg;

    localparam int DEF_RANK_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 32;

    // Ceiling log2, used to size occupancy counters that must hold DEPTH itself
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Default-width entry shared with the multi-port PIFO bank
    typedef struct packed {
        logic                      valid;
        logic [DEF_RANK_WIDTH-1:0] rank;
        logic [DEF_DATA_WIDTH-1:0] data;
    } pifo_entry_t;

endpackage

// File: rtl/pifo_insert_cmp.sv
// rtl/pifo_insert_cmp.sv - parallel rank compare giving stay mask and insert position
module pifo_insert_cmp
    import pifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int RANK_WIDTH = DEF_RANK_WIDTH,
    parameter int CNT_WIDTH  = clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0]            entry_valid,
    input  logic [DEPTH*RANK_WIDTH-1:0] entry_rank,
    input  logic [RANK_WIDTH-1:0]       push_rank,
    output logic [DEPTH-1:0]            stay_mask,
    output logic [CNT_WIDTH-1:0]        insert_pos
);

    // Entries with rank <= push_rank stay put; since the array is sorted the mask is a
    // thermometer and its population count is the insert position (ties go behind)
    always_comb begin
        stay_mask  = '0;
        insert_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stay_mask[i] = entry_valid[i] && (entry_rank[i*RANK_WIDTH +: RANK_WIDTH] <= push_rank);
            insert_pos   = insert_pos + CNT_WIDTH'(stay_mask[i]);
        end
    end

endmodule

// File: rtl/pifo_rank_queue.sv
// rtl/pifo_rank_queue.sv - rank-sorted PIFO descriptor queue; PIFO_EVICT_EN adds tail eviction
module pifo_rank_queue
    import pifo_pkg::*;
#(
    parameter int  DEPTH      = 16,
    parameter int  RANK_WIDTH = DEF_RANK_WIDTH,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int CNT_WIDTH  = clog2(DEPTH + 1)
) (
    input  logic                  clk_in_0,
    input  logic                  reset,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [RANK_WIDTH-1:0] push_rank,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [RANK_WIDTH-1:0] pop_rank,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CNT_WIDTH-1:0]  count,
`ifdef PIFO_EVICT_EN
    output logic                  evict_valid,
    output logic [DATA_WIDTH-1:0] evict_data,
`endif
    output logic                  full,
    output logic                  empty
);

    typedef struct packed {
        logic                  valid;
        logic [RANK_WIDTH-1:0] rank;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t entry_q [DEPTH];
    entry_t entry_d [DEPTH];
    entry_t entry_up [DEPTH];
    entry_t entry_dn [DEPTH];
    entry_t new_entry;

    logic [CNT_WIDTH-1:0]        count_q, count_d;
    logic                        full_q, full_d;
    logic                        empty_q, empty_d;
    logic [DEPTH-1:0]            cmp_valid;
    logic [DEPTH*RANK_WIDTH-1:0] cmp_rank;
    logic [DEPTH-1:0]            stay_mask;
    logic [CNT_WIDTH-1:0]        ins_pos;
    logic [CNT_WIDTH-1:0]        ins_at;
    logic                        push_fire;
    logic                        pop_fire;

    // Entry 0 is the head; invalid slots are kept at zero so an empty queue reads 0
    assign pop_valid = !empty_q;
    assign pop_rank  = entry_q[0].rank;
    assign pop_data  = entry_q[0].data;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

`ifdef PIFO_EVICT_EN
    logic                  evict_valid_q, evict_valid_d;
    logic [DATA_WIDTH-1:0] evict_data_q, evict_data_d;
    logic                  evict_fire;

    // A full queue still accepts a push that outranks the tail, dropping the tail
    assign push_ready  = !full_q || pop_ready || (push_rank < entry_q[DEPTH-1].rank);
    assign evict_fire  = push_fire && full_q && !pop_ready;
    assign evict_valid = evict_valid_q;
    assign evict_data  = evict_data_q;
`else
    // pop_ready frees a slot in the same cycle, so it feeds push_ready combinationally
    assign push_ready = !full_q || pop_ready;
`endif

    assign push_fire = push_valid && push_ready;
    assign pop_fire  = pop_valid && pop_ready;
    assign new_entry = '{valid: 1'b1, rank: push_rank, data: push_data};

    // With a simultaneous pop the head leaves, so the slot found by the compare moves down one
    assign ins_at = (pop_fire && (ins_pos != '0)) ? (ins_pos - CNT_WIDTH'(1)) : ins_pos;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign cmp_valid[g]                         = entry_q[g].valid;
        assign cmp_rank[g*RANK_WIDTH +: RANK_WIDTH] = entry_q[g].rank;
        if (g < DEPTH - 1) begin : g_up
            assign entry_up[g] = entry_q[g+1];
        end else begin : g_up_top
            assign entry_up[g] = '0;
        end
        if (g > 0) begin : g_dn
            assign entry_dn[g] = entry_q[g-1];
        end else begin : g_dn_bot
            assign entry_dn[g] = '0;
        end
    end

    pifo_insert_cmp #(
        .DEPTH      (DEPTH),
        .RANK_WIDTH (RANK_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_insert_cmp (
        .entry_valid (cmp_valid),
        .entry_rank  (cmp_rank),
        .push_rank   (push_rank),
        .stay_mask   (stay_mask),
        .insert_pos  (ins_pos)
    );

    // Next array contents: shift down below the slot on push+pop, shift up above it on push
    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (push_fire && pop_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_WIDTH'(i) < ins_at) begin
                    entry_d[i] = entry_up[i];
                end else if (CNT_WIDTH'(i) == ins_at) begin
                    entry_d[i] = new_entry;
                end
            end
        end else if (push_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_WIDTH'(i) == ins_pos) begin
                    entry_d[i] = new_entry;
                end else if (!stay_mask[i] && (CNT_WIDTH'(i) > ins_pos)) begin
                    entry_d[i] = entry_dn[i];
                end
            end
            if (!full_q) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end else if (pop_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i] = entry_up[i];
            end
            count_d = count_q - CNT_WIDTH'(1);
        end
        full_d  = (count_d == CNT_WIDTH'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Register array and occupancy flags; reset drops every entry and ignores handshakes
    always_ff @(posedge clk_in_0) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

`ifdef PIFO_EVICT_EN
    // The dropped tail payload is reported the cycle after the evicting push
    always_comb begin
        evict_valid_d = evict_fire;
        evict_data_d  = evict_fire ? entry_q[DEPTH-1].data : '0;
    end

    // Eviction strobe register
    always_ff @(posedge clk_in_0) begin
        if (reset) begin
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
        end else begin
            evict_valid_q <= evict_valid_d;
            evict_data_q  <= evict_data_d;
        end
    end
`endif

endmodule
